// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: program counter, loadable instruction memory and the
// IF/ID instruction register, with stall, branch flush and jump/halt pre-decode.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_W = 8,
    parameter logic [4:0]  JMP_OP = 5'b11110,
    parameter logic [4:0]  HLT_OP = 5'b11111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [19:0]       load_data,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [19:0]       ins,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ins_valid,
    output logic              halted
);

    localparam int unsigned INS_W = 20;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic [INS_W-1:0]  ins_q;
    logic              ins_valid_q;
    logic              halted_q;

    logic [INS_W-1:0]  mem_q [DEPTH];

    logic [INS_W-1:0]  rd_word_c;
    logic [4:0]        rd_op_c;
    logic [ADDR_W-1:0] pc_d;

    // Combinational read at pc, with jump pre-decode selecting the next fetch address
    always_comb begin
        rd_word_c = mem_q[pc_q];
        rd_op_c   = rd_word_c[INS_W-1:INS_W-5];
        pc_d      = pc_q + ADDR_W'(1);
        if (rd_op_c == JMP_OP) begin
            pc_d = rd_word_c[ADDR_W-1:0];
        end
    end

    // Memory is written only while loading; contents survive reset
    always_ff @(posedge clk) begin
        if (reset && (state_q == S_LOAD) && load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Control FSM and IF/ID register; branch beats stall, halt ignores stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_LOAD;
            pc_q        <= '0;
            pc_out_q    <= '0;
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    ins_q       <= '0;
                    ins_valid_q <= 1'b0;
                    if (go) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (br_taken) begin
                        pc_q        <= br_target;
                        ins_q       <= '0;
                        ins_valid_q <= 1'b0;
                    end else if (!stall) begin
                        ins_q       <= rd_word_c;
                        pc_out_q    <= pc_q;
                        ins_valid_q <= 1'b1;
                        pc_q        <= pc_d;
                        if (rd_op_c == HLT_OP) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    ins_q       <= '0;
                    ins_valid_q <= 1'b0;
                    if (br_taken) begin
                        pc_q     <= br_target;
                        state_q  <= S_RUN;
                        halted_q <= 1'b0;
                    end else if (go) begin
                        state_q  <= S_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_LOAD;
                    ins_q       <= '0;
                    ins_valid_q <= 1'b0;
                    halted_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ins       = ins_q;
    assign pc_out    = pc_out_q;
    assign ins_valid = ins_valid_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a behavioural model pushes the
// expected IF/ID contents for every applied cycle and the output is popped and compared.
module tb_instruction_fetch_unit;

    localparam logic [4:0] JMP = 5'b11110;
    localparam logic [4:0] HLT = 5'b11111;

    logic        clk = 1'b0;
    logic        rst_n, go, load_en, stall, br_taken;
    logic [7:0]  load_addr, br_target;
    logic [19:0] load_data;
    logic [19:0] ins;
    logic [7:0]  pc_out;
    logic        ins_valid, halted;

    typedef struct packed {
        logic [19:0] ins;
        logic [7:0]  pc;
        logic        v;
        logic        h;
    } exp_t;

    typedef enum int {M_LOAD, M_RUN, M_HALT} mst_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    mst_t        m_st;
    logic [7:0]  m_pc;
    exp_t        m_out;
    logic [19:0] m_mem [256];
    logic [19:0] img   [256];

    always #5 clk = ~clk;

    instruction_fetch_unit #(.ADDR_W(8)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .go        (go),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .ins       (ins),
        .pc_out    (pc_out),
        .ins_valid (ins_valid),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st  = M_LOAD;
        m_pc  = 8'h00;
        m_out = '0;
        sb_q.delete();
    endtask

    // One clock of stimulus: drive inputs, predict the result, then compare after the edge
    task automatic apply(input logic g, input logic st, input logic br, input logic [7:0] tgt,
                         input logic le, input logic [7:0] la, input logic [19:0] ld);
        exp_t        e;
        logic [19:0] w;
        @(negedge clk);
        go = g; stall = st; br_taken = br; br_target = tgt;
        load_en = le; load_addr = la; load_data = ld;
        case (m_st)
            M_LOAD: begin
                if (le) m_mem[la] = ld;
                if (g) m_st = M_RUN;
            end
            M_RUN: begin
                if (br) begin
                    m_pc = tgt; m_out.ins = '0; m_out.v = 1'b0;
                end else if (!st) begin
                    w = m_mem[m_pc];
                    m_out.ins = w; m_out.pc = m_pc; m_out.v = 1'b1;
                    if (w[19:15] == JMP) m_pc = w[7:0];
                    else m_pc = m_pc + 8'd1;
                    if (w[19:15] == HLT) begin
                        m_st = M_HALT; m_out.h = 1'b1;
                    end
                end
            end
            default: begin
                m_out.ins = '0; m_out.v = 1'b0;
                if (br) begin
                    m_pc = tgt; m_st = M_RUN; m_out.h = 1'b0;
                end else if (g) begin
                    m_st = M_RUN; m_out.h = 1'b0;
                end
            end
        endcase
        sb_q.push_back(m_out);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("ins",       32'(ins),       32'(e.ins));
        check("pc_out",    32'(pc_out),    32'(e.pc));
        check("ins_valid", 32'(ins_valid), 32'(e.v));
        check("halted",    32'(halted),    32'(e.h));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
    endtask

    task automatic redirect(input logic [7:0] tgt);
        apply(1'b0, 1'b0, 1'b1, tgt, 1'b0, 8'h00, 20'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            img[i] = {5'(i % 29), 7'(i * 3), 8'(i ^ 8'h5A)};
        end
        img[0] = 20'b00000000010001000011;
        img[1] = 20'b10100001000000100000;
        img[3] = {HLT, 15'h0123};
        img[5] = {JMP, 7'b0, 8'h10};

        go = 0; load_en = 0; stall = 0; br_taken = 0;
        load_addr = 0; br_target = 0; load_data = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_ins",    32'(ins),       32'h0);
        check("rst_pc_out", 32'(pc_out),    32'h0);
        check("rst_valid",  32'(ins_valid), 32'h0);
        check("rst_halted", 32'(halted),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load the whole memory; go arrives together with the final write
        for (int i = 0; i < 256; i++) begin
            apply(i == 255, 1'b0, 1'b0, 8'h00, 1'b1, 8'(i), img[i]);
        end

        run(1);
        check("first_ins",   32'(ins),    32'(20'b00000000010001000011));
        check("first_pc",    32'(pc_out), 32'h00);
        check("first_valid", 32'(ins_valid), 32'h1);
        run(1);
        check("second_ins", 32'(ins), 32'(20'b10100001000000100000));

        // Stall holds mem[1] for two cycles, then mem[2]
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
        check("stall_pc", 32'(pc_out), 32'h01);
        run(1);
        check("after_stall_ins", 32'(ins), 32'(img[2]));

        // Branch together with stall flushes, then fetches the target
        apply(1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 20'h0);
        check("flush_valid", 32'(ins_valid), 32'h0);
        run(1);
        check("br_ins", 32'(ins),    32'(img[8'h40]));
        check("br_pc",  32'(pc_out), 32'h40);
        run(2);

        // Jump pre-decode: no bubble after the jump word
        redirect(8'h05);
        run(1);
        check("jmp_ins", 32'(ins), 32'(img[5]));
        run(1);
        check("jmp_tgt_ins",   32'(ins),       32'(img[8'h10]));
        check("jmp_tgt_valid", 32'(ins_valid), 32'h1);
        run(1);

        // Halt, ignored load/stall while halted, resume with go
        redirect(8'h03);
        run(1);
        check("hlt_ins", 32'(ins), 32'(img[3]));
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 20'hABCDE);
        check("halt_flag", 32'(halted), 32'h1);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 20'hABCDE);
        apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
        run(1);
        check("resume_ins", 32'(ins),    32'(img[4]));
        check("resume_pc",  32'(pc_out), 32'h04);

        // Wrong-path halt: branch wins over go
        redirect(8'h03);
        run(2);
        apply(1'b1, 1'b0, 1'b1, 8'h20, 1'b0, 8'h00, 20'h0);
        check("wp_halted", 32'(halted), 32'h0);
        run(1);
        check("wp_ins", 32'(ins), 32'(img[8'h20]));

        // PC wrap-around
        redirect(8'hFF);
        run(1);
        check("wrap_pc_ff", 32'(pc_out), 32'hFF);
        run(1);
        check("wrap_pc_00", 32'(pc_out), 32'h00);
        run(1);

        // Asynchronous reset mid-cycle, memory preserved afterwards
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_ins",    32'(ins),       32'h0);
        check("arst_pc",     32'(pc_out),    32'h0);
        check("arst_valid",  32'(ins_valid), 32'h0);
        check("arst_halted", 32'(halted),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run(2);
        apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
        run(1);
        check("post_rst_ins", 32'(ins), 32'(img[0]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the 8-bit MIPS pipeline and the producer of the 20-bit instruction word consumed by the dependency check block. It holds the program counter and a loadable instruction memory, and registers one instruction per cycle into the IF/ID register. It honours stall requests from the dependency check and flush/redirect requests from execute, and it pre-decodes unconditional jump and halt in the fetch stage.

Parameters:
ADDR_W, 8, PC / instruction-memory address width; memory depth = 2**ADDR_W words of 20 bits
JMP_OP, 5'b11110, opcode (ins[19:15]) of the unconditional jump; target address = ins[ADDR_W-1:0]
HLT_OP, 5'b11111, opcode of halt

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
go  input  1  pulse: LOAD->RUN, or HALT->RUN
load_en  input  1  instruction-memory write enable, honoured only in LOAD
load_addr  input  ADDR_W  instruction-memory write address
load_data  input  20  instruction word to write
stall  input  1  hold request from the dependency check block
br_taken  input  1  redirect/flush request from execute
br_target  input  ADDR_W  redirect address
ins  output  20  IF/ID instruction register, feeds the dependency check block's ins input
pc_out  output  ADDR_W  address of the word currently in ins
ins_valid  output  1  ins holds a real instruction (0 = bubble)
halted  output  1  high while in HALT

Behaviour:
- Reset (reset=0, async): pc=0, ins=20'b0 (bubble/NOP), pc_out=0, ins_valid=0, halted=0, state=LOAD. Memory contents are not cleared. Reset mid-run aborts immediately with no partial writes.
- Memory: reg array with combinational read at pc. Synchronous write at the clk edge when state=LOAD and load_en=1. load_en in RUN or HALT is ignored.
- States: LOAD, RUN, HALT.
- LOAD: ins=0, ins_valid=0. go=1 -> RUN with pc unchanged (0 after reset). load_en and go in the same cycle: the write happens and the state moves to RUN.
- RUN, evaluated each edge with priority br_taken > stall > fetch:
  - br_taken=1: pc<=br_target, ins<=0, ins_valid<=0. This wins over a simultaneous stall.
  - stall=1: pc, ins, pc_out and ins_valid all hold.
  - fetch: ins<=mem[pc], pc_out<=pc, ins_valid<=1. Next pc:
    - op==JMP_OP: pc<=mem[pc][ADDR_W-1:0], with no bubble.
    - op==HLT_OP: pc<=pc+1, state<=HALT. The HLT word is still presented in ins for one cycle.
    - otherwise: pc<=pc+1.
- Latency: word at address A appears on ins one cycle after the edge on which pc=A is fetched. Steady state delivers one instruction per cycle.
- Wrap-around: pc=2**ADDR_W-1 increments to 0 (modulo ADDR_W bits).
- HALT: halted=1. On the edge after entry, ins<=0 and ins_valid<=0. After that, stall has no effect. pc holds.
  - go=1: -> RUN, fetching from the held pc (the address after HLT).
  - br_taken=1: the HLT was on the wrong path. pc<=br_target, ins<=0, ins_valid<=0, state<=RUN, halted<=0. Takes priority over go.
- go in RUN is ignored.

Test Plan:
- Reset and load: assert reset=0, release, load mem[0]=20'b00000000010001000011, mem[1]=20'b10100001000000100000, pulse go -> ins equals mem[0] with pc_out=0, ins_valid=1, then mem[1] with pc_out=1 on consecutive cycles. Before go, ins=0 and ins_valid=0.
- Stall: stall=1 for 2 cycles while ins=mem[1] -> ins, pc_out=1 and ins_valid hold for exactly 2 cycles, then mem[2] appears.
- Branch flush: br_taken=1 and stall=1 together with br_target=8'h40 -> the next cycle has ins=0 and ins_valid=0. The cycle after that has ins=mem[8'h40] and pc_out=8'h40.
- Jump pre-decode: mem[5]={5'b11110,7'b0,8'h10} -> ins=mem[5], then ins=mem[8'h10] on the next cycle with no bubble.
- Halt/resume and wrong-path halt: mem[3]=HLT -> HLT word is presented, then halted=1, ins=0, and load_en writes are ignored. go -> ins=mem[4]. Repeat the HALT and raise br_taken with br_target=8'h20 -> halted=0, then ins=mem[8'h20].
- Wrap and async reset: run from pc=8'hFF -> next pc_out=8'h00. Pull reset low mid-cycle -> ins=0, pc_out=0, state=LOAD immediately without waiting for clk.
